// File: rtl/mem_arb_pkg.sv
// Shared constants, types and helpers for the memory port arbiter.
package mem_arb_pkg;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  // Tag id field is sized for the largest requester count we expect to share a port.
  localparam int TAG_ID_W  = 8;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } rd_tag_t;

endpackage

// File: rtl/mem_port_arbiter_rr_grant.sv
// Combinational grant selection: round-robin from the requester after ptr, or
// fixed priority where the lowest index wins.
module rr_grant
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ    = 3,
  parameter int FIXED_PRIO = ARB_RR,
  parameter int IDX_W      = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx
);

  // Fixed priority is a rotation that always starts just after the top index.
  logic [IDX_W-1:0] base;

  assign base = (FIXED_PRIO == ARB_FIXED) ? IDX_W'(NUM_REQ - 1) : ptr;

  always_comb begin
    gnt = '0;
    idx = '0;
    // Scan farthest-to-nearest so the nearest asserted requester overwrites last.
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req[(int'(base) + k) % NUM_REQ]) begin
        gnt                                 = '0;
        gnt[(int'(base) + k) % NUM_REQ]     = 1'b1;
        idx                                 = IDX_W'((int'(base) + k) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between NUM_REQ masters and routes read data
// back to the issuing requester after the memory's read latency.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int  NUM_REQ    = 3,
  parameter int  ADDR_W     = 17,
  parameter int  DATA_W     = 12,
  parameter int  RD_LAT     = 1,
  parameter int  FIXED_PRIO = ARB_RR,
  localparam int ID_W       = id_width(NUM_REQ)
) (
  input  logic                      clock,
  input  logic                      nreset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_wen,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      mem_en,
  output logic                      mem_wen,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_din,
  input  logic [DATA_W-1:0]         mem_dout,
  output logic [ID_W-1:0]           grant_id
);

  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_idx;
  logic [ID_W-1:0]    ptr;
  logic               xfer;
  rd_tag_t            tag_p0;
  rd_tag_t            tag_pipe_p1 [RD_LAT];
  rd_tag_t            tag_out;

  rr_grant #(
    .NUM_REQ    (NUM_REQ),
    .FIXED_PRIO (FIXED_PRIO),
    .IDX_W      (ID_W)
  ) u_grant (
    .req (req_valid),
    .ptr (ptr),
    .gnt (gnt),
    .idx (gnt_idx)
  );

  // No handshake completes while reset is held, so pending requests re-arbitrate afterwards.
  assign req_ready = nreset ? gnt : '0;
  assign xfer      = |req_ready;

  always_ff @(posedge clock) begin
    if (!nreset) begin
      ptr      <= ID_W'(NUM_REQ - 1);
      grant_id <= '0;
    end else if (xfer) begin
      ptr      <= gnt_idx;
      grant_id <= gnt_idx;
    end
  end

  // Stage p0: registered memory drive, read tag launched alongside mem_en.
  always_ff @(posedge clock) begin
    if (!nreset || !xfer) begin
      mem_en   <= 1'b0;
      mem_wen  <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
      tag_p0   <= '0;
    end else begin
      mem_en       <= 1'b1;
      mem_wen      <= req_wen[gnt_idx];
      mem_addr     <= req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
      mem_din      <= req_wdata[int'(gnt_idx)*DATA_W +: DATA_W];
      tag_p0.valid <= !req_wen[gnt_idx];
      tag_p0.id    <= TAG_ID_W'(gnt_idx);
    end
  end

  // Stages p1..: tag delayed by the memory read latency.
  always_ff @(posedge clock) begin
    if (!nreset) begin
      for (int k = 0; k < RD_LAT; k++) tag_pipe_p1[k] <= '0;
    end else begin
      tag_pipe_p1[0] <= tag_p0;
      for (int k = 1; k < RD_LAT; k++) tag_pipe_p1[k] <= tag_pipe_p1[k-1];
    end
  end

  assign tag_out = tag_pipe_p1[RD_LAT-1];

  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_valid[i] = tag_out.valid && (tag_out.id == TAG_ID_W'(i));
    end
    rsp_rdata = tag_out.valid ? mem_dout : '0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Two arbiter instances (round-robin with 3-cycle memory, fixed priority with
// 1-cycle memory) driven by directed and random traffic against a reference model.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int N  = 3;
  localparam int AW = 17;
  localparam int DW = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;

  typedef struct {
    int            id;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int FP = (g == 0) ? ARB_RR : ARB_FIXED;
    localparam int RL = (g == 0) ? 3 : 1;

    logic            nrst;
    logic [N-1:0]    rv, wen, rdy, rspv;
    logic [N-1:0]    acc = '0;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wdata;
    logic [DW-1:0]   rdata, mdin, mdout;
    logic            men, mwen;
    logic [AW-1:0]   maddr;
    logic [1:0]      gid;

    int              cyc = 0;
    exp_t            sbq [$];
    int              glog [$];
    logic [DW-1:0]   last_rdata = '0;
    bit   [DW-1:0]   bram [0:(1<<AW)-1];
    bit   [DW-1:0]   rd_pipe [RL];
    logic [DW-1:0]   ref_mem [int];
    bit              preloaded = 1'b0;

    int              last_g = N - 1;
    logic [1:0]      e_gid = '0;
    logic            e_en = 1'b0, e_wen = 1'b0, post_rst = 1'b0;
    logic [AW-1:0]   e_addr = '0;
    logic [DW-1:0]   e_din = '0;

    mem_port_arbiter #(
      .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL), .FIXED_PRIO(FP)
    ) dut (
      .clock(clk), .nreset(nrst),
      .req_valid(rv), .req_ready(rdy), .req_wen(wen), .req_addr(addr), .req_wdata(wdata),
      .rsp_valid(rspv), .rsp_rdata(rdata),
      .mem_en(men), .mem_wen(mwen), .mem_addr(maddr), .mem_din(mdin), .mem_dout(mdout),
      .grant_id(gid)
    );

    // Block RAM with RL cycles from enable to data.
    always @(posedge clk) begin
      if (cyc == 0) bram[16] <= 12'hABC;
      if (men && mwen) bram[maddr] <= mdin;
      rd_pipe[0] <= (men && !mwen) ? bram[maddr] : '0;
      for (int k = 1; k < RL; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign mdout = rd_pipe[RL-1];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string nm(input string s);
      return $sformatf("lane%0d_%s", g, s);
    endfunction

    function automatic int glog_at(input int k);
      return (k < glog.size()) ? glog[k] : -1;
    endfunction

    // Reference model: arbitration rule, memory contents in grant order, expected responses.
    always @(negedge clk) begin : model
      int            gi;
      logic [N-1:0]  eg;
      logic [AW-1:0] a;
      if (!preloaded) begin
        ref_mem[16] = 12'hABC;
        preloaded   = 1'b1;
      end
      chk(nm("mem_en"), 64'(men), 64'(e_en));
      chk(nm("mem_wen"), 64'(mwen), 64'(e_wen));
      chk(nm("mem_addr"), 64'(maddr), 64'(e_addr));
      if (e_en && e_wen) chk(nm("mem_din"), 64'(mdin), 64'(e_din));
      chk(nm("grant_id"), 64'(gid), 64'(e_gid));
      if (post_rst) begin
        chk(nm("rst_rsp_valid"), 64'(rspv), 64'(0));
        chk(nm("rst_rsp_rdata"), 64'(rdata), 64'(0));
      end

      gi = -1;
      if (nrst) begin
        if (FP == ARB_FIXED) begin
          for (int i = 0; i < N; i++) if (rv[i]) begin gi = i; break; end
        end else begin
          for (int k = 1; k <= N; k++) begin
            if (rv[(last_g + k) % N]) begin gi = (last_g + k) % N; break; end
          end
        end
      end
      eg = (gi >= 0) ? (N'(1) << gi) : '0;
      chk(nm("req_ready"), 64'(rdy), 64'(eg));
      acc = rdy & rv;

      e_en = 1'b0; e_wen = 1'b0; e_addr = '0; e_din = '0;
      if (gi >= 0) begin
        a      = addr[gi*AW +: AW];
        last_g = gi;
        e_gid  = 2'(gi);
        glog.push_back(gi);
        e_en   = 1'b1;
        e_wen  = wen[gi];
        e_addr = a;
        e_din  = wdata[gi*DW +: DW];
        if (wen[gi]) ref_mem[int'(a)] = wdata[gi*DW +: DW];
        else sbq.push_back('{gi, ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : '0, cyc + 1 + RL});
      end
      if (!nrst) begin
        last_g = N - 1;
        e_gid  = '0;
        for (int k = sbq.size() - 1; k >= 0; k--) if (sbq[k].due > cyc) sbq.delete(k);
      end
      post_rst = !nrst;
    end

    always @(negedge clk) begin : rsp_mon
      exp_t e;
      if (rspv != '0) begin
        if (sbq.size() == 0) chk(nm("rsp_unexpected"), 64'(rspv), 64'(0));
        else begin
          e = sbq.pop_front();
          chk(nm("rsp_valid"), 64'(rspv), 64'(1) << e.id);
          chk(nm("rsp_rdata"), 64'(rdata), 64'(e.data));
          chk(nm("rsp_cycle"), 64'(cyc), 64'(e.due));
          last_rdata = rdata;
        end
      end else if (sbq.size() != 0 && sbq[0].due <= cyc) begin
        chk(nm("rsp_missing"), 64'(0), 64'(1) << sbq[0].id);
        void'(sbq.pop_front());
      end
    end

    task automatic issue(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      rv[i]              = 1'b1;
      wen[i]             = w;
      addr[i*AW +: AW]   = a;
      wdata[i*DW +: DW]  = d;
    endtask

    task automatic tick();
      @(posedge clk);
      #1;
      rv = rv & ~acc;
    endtask

    task automatic wait_idle(input string tag);
      int n = 0;
      while ((rv != '0 || sbq.size() != 0) && n < 300) begin
        tick();
        n++;
      end
      chk(nm({tag, "_idle"}), 64'(n < 300), 64'(1));
    endtask

    task automatic rand_phase(input int cycles, input bit with_rst);
      for (int c = 0; c < cycles; c++) begin
        for (int i = 0; i < N; i++) begin
          if (!rv[i] && $urandom_range(1) == 1)
            issue(i, 1'($urandom_range(1)),
                  ($urandom_range(3) == 0) ? 17'h1F000 + AW'($urandom_range(3)) : AW'($urandom_range(15)),
                  DW'($urandom));
        end
        nrst = with_rst ? ($urandom_range(63) != 0) : 1'b1;
        tick();
      end
      nrst = 1'b1;
    endtask

    initial begin : drive
      int issued;
      int n;
      int fx_exp [5];
      fx_exp = '{0, 0, 0, 0, 2};
      nrst = 1'b0; rv = '0; wen = '0; addr = '0; wdata = '0;
      repeat (2) @(posedge clk);
      #1 nrst = 1'b1;
      if (FP == ARB_RR) begin
        glog.delete();
        for (int i = 0; i < N; i++) issue(i, 1'b0, AW'(i + 32), '0);
        issued = 3;
        n = 0;
        while (glog.size() < 6 && n < 50) begin
          tick();
          for (int i = 0; i < N; i++) begin
            if (!rv[i] && issued < 6) begin
              issue(i, 1'b0, AW'(i + 40), '0);
              issued++;
            end
          end
          n++;
        end
        wait_idle("rr");
        for (int k = 0; k < 6; k++) chk(nm($sformatf("rr_order%0d", k)), 64'(glog_at(k)), 64'(k % 3));

        glog.delete();
        issue(1, 1'b0, AW'(5), '0);
        tick();
        nrst = 1'b0;
        issue(2, 1'b0, AW'(6), '0);
        issue(0, 1'b0, AW'(7), '0);
        tick();
        nrst = 1'b1;
        wait_idle("rst");
        chk(nm("rst_pre_grant"), 64'(glog_at(0)), 64'(1));
        chk(nm("rst_first_grant"), 64'(glog_at(1)), 64'(0));
        chk(nm("rst_second_grant"), 64'(glog_at(2)), 64'(2));

        rand_phase(400, 1'b1);
        wait_idle("rand");
      end else begin
        glog.delete();
        issue(1, 1'b0, 17'h00010, '0);
        wait_idle("single");
        chk(nm("single_grant"), 64'(glog_at(0)), 64'(1));
        chk(nm("single_count"), 64'(glog.size()), 64'(1));
        chk(nm("single_rdata"), 64'(last_rdata), 64'(12'hABC));

        glog.delete();
        issue(0, 1'b0, AW'(1), '0);
        issue(2, 1'b0, AW'(2), '0);
        for (int k = 0; k < 4; k++) begin
          tick();
          if (k < 3) issue(0, 1'b0, AW'(k + 3), '0);
        end
        wait_idle("fixed");
        for (int k = 0; k < 5; k++) chk(nm($sformatf("fixed_order%0d", k)), 64'(glog_at(k)), 64'(fx_exp[k]));

        glog.delete();
        issue(0, 1'b1, 17'h1F000, 12'h5A5);
        tick();
        issue(2, 1'b0, 17'h1F000, '0);
        wait_idle("hazard");
        chk(nm("hazard_grant"), 64'(glog_at(1)), 64'(2));
        chk(nm("hazard_rdata"), 64'(last_rdata), 64'(12'h5A5));

        rand_phase(400, 1'b0);
        wait_idle("rand");
      end
      done_cnt++;
    end
  end

  initial begin
    for (int t = 0; t < 20000 && done_cnt < 2; t++) @(posedge clk);
    chk("all_lanes_done", 64'(done_cnt), 64'(2));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
